// File: rtl/babbage_inverse_f.sv
// Floor inverse of f(n) = 2n^2 + 3n + 5: walks f upward by forward differences until the next step would pass y.
// Optional residual output y - f(n_out) is enabled by defining BABBAGE_INV_RESID_EN.
module babbage_inverse_f #(
    parameter int N_W = 6,
    parameter int F_W = 14
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [F_W-1:0] in,
    output logic           ready,
    output logic           done_tick,
    output logic [N_W-1:0] n_out,
    output logic           exact,
    output logic           under,
`ifdef BABBAGE_INV_RESID_EN
    output logic [F_W-1:0] resid,
`endif
    output logic           ovf
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [F_W-1:0] F0    = F_W'(5);
    localparam logic [F_W-1:0] G1    = F_W'(5);
    localparam logic [F_W-1:0] G_INC = F_W'(4);
    localparam logic [N_W-1:0] N_MAX = {N_W{1'b1}};

    logic [1:0]     state_q, state_d;
    logic [N_W-1:0] i_q, i_d;
    logic [F_W-1:0] f_q, f_d;
    logic [F_W-1:0] g_q, g_d;
    logic [F_W-1:0] target_q, target_d;
    logic [N_W-1:0] n_out_q, n_out_d;
    logic           exact_q, exact_d;
    logic           under_q, under_d;
    logic           ovf_q, ovf_d;
    logic [F_W-1:0] resid_q, resid_d;
    logic [F_W:0]   next_f_s;

    // Next-state and datapath update; results are written only on the calc exit cycle.
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        f_d      = f_q;
        g_d      = g_q;
        target_d = target_q;
        n_out_d  = n_out_q;
        exact_d  = exact_q;
        under_d  = under_q;
        ovf_d    = ovf_q;
        resid_d  = resid_q;
        // One extra bit so a step past the top of the range cannot wrap below the target.
        next_f_s = {1'b0, f_q} + {1'b0, g_q};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    target_d = in;
                    i_d      = '0;
                    f_d      = F0;
                    g_d      = G1;
                    state_d  = S_CALC;
                end else begin
                    state_d  = S_IDLE;
                end
            end
            S_CALC: begin
                if (target_q < F0) begin
                    under_d = 1'b1;
                    n_out_d = '0;
                    exact_d = 1'b0;
                    ovf_d   = 1'b0;
                    resid_d = target_q;
                    state_d = S_DONE;
                end else if ((i_q == N_MAX) || (next_f_s > {1'b0, target_q})) begin
                    n_out_d = i_q;
                    exact_d = (f_q == target_q);
                    ovf_d   = (i_q == N_MAX) && (f_q < target_q);
                    under_d = 1'b0;
                    resid_d = target_q - f_q;
                    state_d = S_DONE;
                end else begin
                    i_d = i_q + N_W'(1);
                    f_d = next_f_s[F_W-1:0];
                    g_d = g_q + G_INC;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            i_q      <= '0;
            f_q      <= '0;
            g_q      <= '0;
            target_q <= '0;
            n_out_q  <= '0;
            exact_q  <= 1'b0;
            under_q  <= 1'b0;
            ovf_q    <= 1'b0;
            resid_q  <= '0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            f_q      <= f_d;
            g_q      <= g_d;
            target_q <= target_d;
            n_out_q  <= n_out_d;
            exact_q  <= exact_d;
            under_q  <= under_d;
            ovf_q    <= ovf_d;
            resid_q  <= resid_d;
        end
    end

    assign ready     = (state_q == S_IDLE);
    assign done_tick = (state_q == S_DONE);
    assign n_out     = n_out_q;
    assign exact     = exact_q;
    assign under     = under_q;
    assign ovf       = ovf_q;
`ifdef BABBAGE_INV_RESID_EN
    assign resid     = resid_q;
`endif

endmodule

// File: tb/tb_babbage_inverse_f.sv
// Scoreboard bench for babbage_inverse_f: expectations come from a direct evaluation of f(n) = 2n^2 + 3n + 5.
module tb_babbage_inverse_f;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [13:0] in;
    logic        ready;
    logic        done_tick;
    logic [5:0]  n_out;
    logic        exact;
    logic        under;
    logic        ovf;
`ifdef BABBAGE_INV_RESID_EN
    logic [13:0] resid;
`endif

    int checks = 0;
    int errors = 0;

    typedef struct {
        int n;
        int ex;
        int un;
        int ov;
        int rs;
        int lat;
    } exp_t;

    exp_t sb_q[$];

    babbage_inverse_f dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .in        (in),
        .ready     (ready),
        .done_tick (done_tick),
        .n_out     (n_out),
        .exact     (exact),
        .under     (under),
`ifdef BABBAGE_INV_RESID_EN
        .resid     (resid),
`endif
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    function automatic int f_of(int n);
        return 2 * n * n + 3 * n + 5;
    endfunction

    function automatic exp_t model(int y);
        exp_t e;
        e.n = 0; e.ex = 0; e.un = 0; e.ov = 0; e.rs = 0;
        if (y < 5) begin
            e.un = 1;
            e.rs = y;
        end else begin
            for (int k = 0; k < 64; k++) begin
                if (f_of(k) <= y) e.n = k;
            end
            e.ex = (f_of(e.n) == y) ? 1 : 0;
            e.ov = (y > f_of(63)) ? 1 : 0;
            e.rs = y - f_of(e.n);
        end
        e.lat = e.n + 2;
        return e;
    endfunction

    task automatic check_reset_state(input string tag);
        check_val({tag, "_ready"}, ready, 1);
        check_val({tag, "_done"}, done_tick, 0);
        check_val({tag, "_n"}, n_out, 0);
        check_val({tag, "_exact"}, exact, 0);
        check_val({tag, "_under"}, under, 0);
        check_val({tag, "_ovf"}, ovf, 0);
`ifdef BABBAGE_INV_RESID_EN
        check_val({tag, "_resid"}, resid, 0);
`endif
    endtask

    // One run: push expectation at start, pop and compare at done_tick. poke drives a stray start mid-calc.
    task automatic run_one(input int y, input bit poke);
        int   cyc;
        exp_t e;
        cyc = 0;
        while (!ready && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_val("ready_wait", ready, 1);
        start = 1'b1;
        in    = 14'(y);
        sb_q.push_back(model(y));
        @(negedge clk);
        cyc = 1;
        while (!done_tick && cyc < 100) begin
            start = poke && (cyc == 3);
            if (poke && (cyc == 3)) in = 14'd5;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        check_val("done_seen", done_tick, 1);
        e = sb_q.pop_front();
        check_val("latency", cyc, e.lat);
        check_val("n_out", n_out, e.n);
        check_val("exact", exact, e.ex);
        check_val("under", under, e.un);
        check_val("ovf", ovf, e.ov);
`ifdef BABBAGE_INV_RESID_EN
        check_val("resid", resid, e.rs);
`endif
        @(negedge clk);
        check_val("pulse_end", done_tick, 0);
        check_val("ready_after", ready, 1);
        repeat (2) @(negedge clk);
        check_val("hold_n", n_out, e.n);
        check_val("hold_exact", exact, e.ex);
    endtask

    initial begin
        int  y_list[10];
        bit  seen_done;
        reset = 1'b1;
        start = 1'b0;
        in    = 14'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check_reset_state("reset");

        y_list = '{32, 33, 40, 49, 4, 5, 8132, 16383, 0, 19};
        foreach (y_list[k]) begin
            run_one(y_list[k], y_list[k] == 8132);
        end

        // Abort a long run with reset; no done_tick may appear and results clear.
        start = 1'b1;
        in    = 14'd1000;
        @(negedge clk);
        start = 1'b0;
        seen_done = 1'b0;
        repeat (9) begin
            @(negedge clk);
            if (done_tick) seen_done = 1'b1;
        end
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check_val("abort_no_done", seen_done, 0);
        check_reset_state("abort");
        repeat (3) begin
            @(negedge clk);
            if (done_tick) seen_done = 1'b1;
        end
        check_val("abort_quiet", seen_done, 0);

        run_one(19, 1'b0);
        for (int r = 0; r < 6; r++) begin
            run_one(int'($urandom_range(0, 9000)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
